// File: rtl/bird_physics.sv
`default_nettype none
// ============================================================================
// Module   : bird_physics
// Purpose  : Bird vertical-motion integrator and IDLE/PLAY/DEAD game FSM,
//            advanced once per rising edge of the divided game clock.
// Revision : 1.0  initial release
// ============================================================================
module bird_physics #(
    parameter int Y_W       = 10,
    parameter int SCREEN_H  = 480,
    parameter int BIRD_H    = 16,
    parameter int Y_START   = 232,
    parameter int GRAVITY   = 1,
    parameter int FLAP_VEL  = -8,
    parameter int VMAX      = 10,
    parameter int DEAD_HOLD = 50
) (
    input  logic           clock_in,
    input  logic           rst,
    input  logic           clk_game,
    input  logic           flap_btn,
    input  logic           hit,
    output logic [Y_W-1:0] bird_y,
    output logic [7:0]     bird_vel,
    output logic [1:0]     state,
    output logic           game_over,
    output logic           game_tick
);

    localparam int                    CNT_W   = $clog2(DEAD_HOLD + 1);
    localparam logic signed [Y_W+1:0] c_floor = (Y_W+2)'(SCREEN_H - BIRD_H);
    localparam logic [Y_W-1:0]        c_ystart = Y_W'(Y_START);
    localparam logic [Y_W-1:0]        c_yfloor = Y_W'(SCREEN_H - BIRD_H);
    localparam logic signed [8:0]     c_grav  = 9'(GRAVITY);
    localparam logic signed [8:0]     c_vmax  = 9'(VMAX);
    localparam logic [7:0]            c_flap  = 8'(FLAP_VEL);
    localparam logic [CNT_W-1:0]      c_hold  = CNT_W'(DEAD_HOLD);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    state_t              r_state;
    logic [Y_W-1:0]      r_bird_y;
    logic [7:0]          r_bird_vel;
    logic                r_game_over;
    logic                r_game_tick;
    logic                r_clk_game_d;
    logic                r_flap_d;
    logic                r_flap_pending;
    logic [CNT_W-1:0]    r_hold;

    logic                  w_flap_rise;
    logic                  w_flap;
    logic signed [8:0]     w_vel_inc;
    logic [7:0]            w_vel_n;
    logic signed [Y_W+1:0] w_y_n;

    assign w_flap_rise = flap_btn & ~r_flap_d;
    // A rise coinciding with the tick is folded into that tick's flap.
    assign w_flap      = r_flap_pending | w_flap_rise;
    assign w_vel_inc   = $signed({r_bird_vel[7], r_bird_vel}) + c_grav;
    assign w_vel_n     = w_flap ? c_flap :
                         (w_vel_inc > c_vmax) ? c_vmax[7:0] : w_vel_inc[7:0];
    assign w_y_n       = $signed({2'b00, r_bird_y}) +
                         $signed({{(Y_W-6){w_vel_n[7]}}, w_vel_n});

    always_ff @(posedge clock_in) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_bird_y       <= c_ystart;
            r_bird_vel     <= 8'd0;
            r_game_over    <= 1'b0;
            r_game_tick    <= 1'b0;
            r_clk_game_d   <= 1'b0;
            r_flap_d       <= 1'b0;
            r_flap_pending <= 1'b0;
            r_hold         <= '0;
        end else begin
            r_clk_game_d <= clk_game;
            r_game_tick  <= clk_game & ~r_clk_game_d;
            r_flap_d     <= flap_btn;
            case (r_state)
                S_IDLE: begin
                    if (w_flap_rise) begin
                        r_state        <= S_PLAY;
                        r_flap_pending <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (hit) begin
                        r_state        <= S_DEAD;
                        r_game_over    <= 1'b1;
                        r_bird_vel     <= 8'd0;
                        r_flap_pending <= 1'b0;
                        r_hold         <= '0;
                    end else if (r_game_tick) begin
                        r_flap_pending <= 1'b0;
                        if (w_y_n[Y_W+1]) begin
                            r_bird_y   <= '0;
                            r_bird_vel <= 8'd0;
                        end else if (w_y_n >= c_floor) begin
                            r_bird_y    <= c_yfloor;
                            r_bird_vel  <= 8'd0;
                            r_state     <= S_DEAD;
                            r_game_over <= 1'b1;
                            r_hold      <= '0;
                        end else begin
                            r_bird_y   <= w_y_n[Y_W-1:0];
                            r_bird_vel <= w_vel_n;
                        end
                    end else if (w_flap_rise) begin
                        r_flap_pending <= 1'b1;
                    end
                end
                S_DEAD: begin
                    r_flap_pending <= 1'b0;
                    r_bird_vel     <= 8'd0;
                    if (w_flap_rise && (r_hold == c_hold)) begin
                        r_state     <= S_IDLE;
                        r_bird_y    <= c_ystart;
                        r_game_over <= 1'b0;
                        r_hold      <= '0;
                    end else if (r_game_tick && (r_hold != c_hold)) begin
                        r_hold <= r_hold + CNT_W'(1);
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_bird_y       <= c_ystart;
                    r_bird_vel     <= 8'd0;
                    r_game_over    <= 1'b0;
                    r_flap_pending <= 1'b0;
                    r_hold         <= '0;
                end
            endcase
        end
    end

    assign bird_y    = r_bird_y;
    assign bird_vel  = r_bird_vel;
    assign state     = r_state;
    assign game_over = r_game_over;
    assign game_tick = r_game_tick;

endmodule
`default_nettype wire

// File: tb/tb_bird_physics.sv
`default_nettype none
// ============================================================================
// Module   : tb_bird_physics
// Purpose  : Directed self-checking bench for bird_physics.
// Revision : 1.0  initial release
// ============================================================================
module tb_bird_physics;

    logic       clk;
    logic       rst;
    logic       clk_game;
    logic       flap_btn;
    logic       hit;
    logic [9:0] bird_y;
    logic [7:0] bird_vel;
    logic [1:0] state;
    logic       game_over;
    logic       game_tick;

    int checks   = 0;
    int failures = 0;

    bird_physics dut (
        .clock_in  (clk),
        .rst       (rst),
        .clk_game  (clk_game),
        .flap_btn  (flap_btn),
        .hit       (hit),
        .bird_y    (bird_y),
        .bird_vel  (bird_vel),
        .state     (state),
        .game_over (game_over),
        .game_tick (game_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int vel();
        return int'($signed(bird_vel));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk) clk_game = 1'b1;
        repeat (3) @(negedge clk);
        clk_game = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic flap();
        @(negedge clk) flap_btn = 1'b1;
        @(negedge clk) flap_btn = 1'b0;
    endtask

    initial begin
        int n;
        int my;
        int mv;
        int ms;
        bit done;

        rst = 1'b1; clk_game = 1'b0; flap_btn = 1'b0; hit = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_y", int'(bird_y), 232);
        chk("rst_vel", vel(), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_over", int'(game_over), 0);
        chk("rst_tick", int'(game_tick), 0);
        rst = 1'b0;

        // Tick pulse must be exactly one clock wide.
        @(negedge clk) clk_game = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (game_tick) n++;
        end
        clk_game = 1'b0;
        chk("tick_width", n, 1);
        repeat (2) @(negedge clk);
        tick(); tick();
        chk("idle_y", int'(bird_y), 232);
        chk("idle_state", int'(state), 0);
        hit = 1'b1; @(negedge clk); hit = 1'b0; @(negedge clk);
        chk("idle_hit_state", int'(state), 0);

        // First flap and one ordinary gravity tick; double rise counts once.
        flap();
        chk("flap_state", int'(state), 1);
        chk("flap_y_hold", int'(bird_y), 232);
        flap();
        tick();
        chk("t1_vel", vel(), -8);
        chk("t1_y", int'(bird_y), 224);
        tick();
        chk("t2_vel", vel(), -7);
        chk("t2_y", int'(bird_y), 217);

        // Velocity walk to saturation.
        do_reset();
        flap(); tick();
        my = 224; mv = -8;
        chk("walk_y0", int'(bird_y), my);
        for (int i = 0; i < 25; i++) begin
            tick();
            mv = (mv + 1 > 10) ? 10 : mv + 1;
            my = my + mv;
            chk($sformatf("walk_vel%0d", i), vel(), mv);
            chk($sformatf("walk_y%0d", i), int'(bird_y), my);
        end

        // Ceiling clamp.
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            flap(); tick();
            if (i == 29) begin
                chk("ceil29_y", int'(bird_y), 0);
                chk("ceil29_vel", vel(), -8);
            end
        end
        chk("ceil30_y", int'(bird_y), 0);
        chk("ceil30_vel", vel(), 0);
        chk("ceil30_state", int'(state), 1);

        // Free fall from the ceiling to the floor.
        my = 0; mv = 0; ms = 1; done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            mv = (mv + 1 > 10) ? 10 : mv + 1;
            if (my + mv >= 464) begin
                my = 464; mv = 0; ms = 2; done = 1'b1;
            end else begin
                my = my + mv;
            end
            chk($sformatf("fall_y%0d", i), int'(bird_y), my);
        end
        chk("floor_done", int'(done), 1);
        chk("floor_y", int'(bird_y), 464);
        chk("floor_vel", vel(), 0);
        chk("floor_state", int'(state), ms);
        chk("floor_over", int'(game_over), 1);

        // Dead hold: 10 and 49 ticks too early, 50 releases.
        repeat (10) tick();
        flap();
        chk("dead10_state", int'(state), 2);
        repeat (39) tick();
        flap();
        chk("dead49_state", int'(state), 2);
        chk("dead49_y", int'(bird_y), 464);
        tick();
        flap();
        chk("dead50_state", int'(state), 0);
        chk("dead50_y", int'(bird_y), 232);
        chk("dead50_vel", vel(), 0);
        chk("dead50_over", int'(game_over), 0);

        // Hit in the same cycle as a tick wins over the position update.
        flap(); tick();
        chk("hit_pre_y", int'(bird_y), 224);
        @(negedge clk) clk_game = 1'b1;
        @(negedge clk) hit = 1'b1;
        chk("hit_tick_hi", int'(game_tick), 1);
        @(negedge clk) hit = 1'b0;
        clk_game = 1'b0;
        @(negedge clk);
        chk("hit_state", int'(state), 2);
        chk("hit_y", int'(bird_y), 224);
        chk("hit_vel", vel(), 0);
        chk("hit_over", int'(game_over), 1);

        // Reset mid-play.
        do_reset();
        flap(); tick(); tick();
        chk("pre_rst_state", int'(state), 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", int'(state), 0);
        chk("midrst_y", int'(bird_y), 232);
        chk("midrst_vel", vel(), 0);
        rst = 1'b0;
        tick();
        chk("midrst_idle_y", int'(bird_y), 232);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
